arb_mux_4x1: RTL and testbench
==============================

// Module: arb_mux_4x1
// PURPOSE
//  Merges four valid/ready streams into one, tagging each beat with its source index.
//  It is the gathering counterpart to the 1-to-4 select demux.
//  Round-robin arbitration, with optional packet locking on in_last.
//  Single registered output stage (1-cycle latency, full throughput).
//  Sits where fanned-out lanes reconverge ahead of a shared consumer.
// PARAMETERS
//  ID            1   instance tag, no functional effect
//  WIDTH         2   data width of each lane
//  LOCK_ON_LAST  1   1: a granted source is held until a beat with in_last is accepted
// PORTS
//  clk        in   1           clock, rising edge
//  rst_n      in   1           asynchronous, active-low reset
//  in_data    in   [3:0][WIDTH] per-lane data
//  in_valid   in   4           per-lane valid
//  in_last    in   4           per-lane end-of-packet marker
//  in_ready   out  4           per-lane ready; at most one bit set (one-hot or zero)
//  out_data   out  WIDTH       registered data
//  out_sel    out  2           source lane of out_data
//  out_last   out  1           registered in_last of the beat
//  out_valid  out  1           output register holds a beat
//  out_ready  in   1           consumer accepts the beat
// BEHAVIOUR
//  - Reset (rst_n=0, async): out_valid=0, out_data=0, out_sel=0, out_last=0.
//    Also rr_ptr=0, state=ARB, in_ready=4'b0000 while in reset.
//    Any held beat and any lock are discarded.
//  - load = ~out_valid | out_ready. The output register can take a new beat this cycle.
//  - Transfer on lane i: in_valid[i] & in_ready[i]. Output transfer: out_valid & out_ready.
//  - State ARB:
//    - The grant g is the first set in_valid bit, scanning rr_ptr, rr_ptr+1, ... mod 4.
//    - in_ready[g] = load; all other in_ready bits are 0.
//    - If no lane is valid, in_ready = 0 and nothing loads.
//  - On accept of lane g (either state), at the next edge:
//    - out_data <= in_data[g], out_sel <= g, out_last <= in_last[g], out_valid <= 1.
//  - In ARB, on accept:
//    - rr_ptr <= g+1 (2-bit wrap, 3 -> 0).
//    - If LOCK_ON_LAST and !in_last[g]: state <= LOCK, lock_sel <= g.
//  - State LOCK:
//    - Only lock_sel is served: in_ready[lock_sel] = load; other lanes are stalled even if valid.
//    - rr_ptr is frozen.
//    - Accept with in_last[lock_sel]=1 -> ARB.
//    - If lock_sel is not valid, hold LOCK and output nothing.
//  - If out_valid & out_ready and nothing is accepted: out_valid <= 0. Data/sel/last keep their old values.
//  - Stall: while out_valid & !out_ready, out_data/out_sel/out_last are stable and in_ready = 0.
//  - Simultaneous output drain and input accept in one cycle: the new beat replaces the old.
//    No bubble; sustained throughput is 1 beat/clk.
//  - in_ready may depend combinationally on in_valid and out_ready.
//    in_valid must not depend on in_ready.
//  - LOCK_ON_LAST=0: the LOCK state is never entered and in_last is passed through only.
// TESTING (WIDTH=8 unless noted)
//  1. Single lane: lane1 valid, data 8'hA5, last=1, out_ready=1.
//     -> Next clk: out_valid=1, out_data=A5, out_sel=1, out_last=1; rr_ptr=2.
//  2. All lanes always valid, last=1, out_ready=1.
//     -> out_sel = 0,1,2,3,0,... one beat per clk, no gaps.
//  3. Backpressure: out_ready=0 for 3 clk with a beat held.
//     -> out_data/out_sel held, in_ready=0000.
//     -> When out_ready rises, the next lane's beat loads on the same edge.
//  4. Lock: lane2 sends 11,22,33 (last on 33) while lane0 holds one beat 44, out_ready=1.
//     -> out_data 11,22,33,44 with out_sel 2,2,2,0.
//  5. Same stimulus as 4 with LOCK_ON_LAST=0.
//     -> out_sel 2,0,2,2 (interleaved, rr pointer honoured).
//  6. Drop rst_n mid-LOCK with out_valid=1.
//     -> out_valid=0 asynchronously.
//     -> After release, with all lanes valid, the first grant is lane0.

Source files
------------

// File: rtl/arb_mux_4x1.sv
// ---------------------------------------------------------------------------
// arb_mux_4x1
//   Merges four valid/ready lanes into one stream. Each output beat carries its
//   source lane index. Lanes are picked round-robin. With LOCK_ON_LAST set, a
//   granted lane keeps the grant until it delivers a beat with in_last. The
//   output is a single register stage: 1-cycle latency, 1 beat/clk sustained.
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_data   in   [3:0][WIDTH] per-lane data
//   in_valid  in   [3:0] per-lane valid
//   in_last   in   [3:0] per-lane end-of-packet marker
//   in_ready  out  [3:0] per-lane ready, one-hot or zero
//   out_data  out  [WIDTH] registered data
//   out_sel   out  [2] source lane of out_data
//   out_last  out  registered in_last of the beat
//   out_valid out  output register holds a beat
//   out_ready in   consumer accepts the beat
// ---------------------------------------------------------------------------
module arb_mux_4x1 #(
   parameter int ID           = 1,
   parameter int WIDTH        = 2,
   parameter int LOCK_ON_LAST = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [3:0][WIDTH-1:0]  in_data,
   input  logic [3:0]             in_valid,
   input  logic [3:0]             in_last,
   output logic [3:0]             in_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic [1:0]             out_sel,
   output logic                   out_last,
   output logic                   out_valid,
   input  logic                   out_ready
);

   typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_t;

   // ID is a tag only; folding it in with a zero factor keeps it referenced
   // without changing the round-robin start point.
   localparam logic [1:0] RR_RST = 2'(ID * 0);

   state_t           r_state;
   logic [1:0]       r_rr_ptr;
   logic [1:0]       r_lock_sel;
   logic [WIDTH-1:0] r_data;
   logic [1:0]       r_sel;
   logic             r_last;
   logic             r_valid;

   logic             w_load;
   logic             w_any;
   logic [1:0]       w_gnt;
   logic             w_acc;

   // Output register can take a beat when empty or being drained this cycle.
   assign w_load = ~r_valid | out_ready;

   // Grant selection. In ARB the scan runs from rr_ptr upward; iterating
   // from the far end lets the nearest valid lane overwrite the others.
   always_comb begin
      logic [1:0] v_idx;
      w_gnt = r_rr_ptr;
      w_any = 1'b0;
      v_idx = 2'd0;
      if (r_state == ST_LOCK) begin
         w_gnt = r_lock_sel;
         w_any = in_valid[r_lock_sel];
      end else begin
         for (int k = 3; k >= 0; k--) begin
            v_idx = r_rr_ptr + 2'(k);
            if (in_valid[v_idx]) begin
               w_gnt = v_idx;
               w_any = 1'b1;
            end
         end
      end
   end

   // rst_n gates the handshake so no lane sees ready while held in reset.
   assign w_acc = w_any & w_load & rst_n;

   for (genvar g = 0; g < 4; g++) begin : g_rdy
      assign in_ready[g] = w_acc & (w_gnt == 2'(g));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_ARB;
         r_rr_ptr   <= RR_RST;
         r_lock_sel <= 2'd0;
         r_data     <= '0;
         r_sel      <= 2'd0;
         r_last     <= 1'b0;
         r_valid    <= 1'b0;
      end else begin
         if (w_acc) begin
            // A drain in the same cycle is simply overwritten: no bubble.
            r_data  <= in_data[w_gnt];
            r_sel   <= w_gnt;
            r_last  <= in_last[w_gnt];
            r_valid <= 1'b1;
         end else if (out_ready) begin
            r_valid <= 1'b0;
         end

         case (r_state)
            ST_ARB: begin
               if (w_acc) begin
                  r_rr_ptr <= w_gnt + 2'd1;
                  if ((LOCK_ON_LAST != 0) && !in_last[w_gnt]) begin
                     r_state    <= ST_LOCK;
                     r_lock_sel <= w_gnt;
                  end
               end
            end
            ST_LOCK: begin
               // rr_ptr stays frozen while a packet is in flight.
               if (w_acc && in_last[w_gnt]) r_state <= ST_ARB;
            end
            default: r_state <= ST_ARB;
         endcase
      end
   end

   assign out_data  = r_data;
   assign out_sel   = r_sel;
   assign out_last  = r_last;
   assign out_valid = r_valid;

endmodule

// File: tb/tb_arb_mux_4x1.sv
// ---------------------------------------------------------------------------
// tb_arb_mux_4x1
//   Two instances with WIDTH=8: index 0 has LOCK_ON_LAST=1, index 1 has
//   LOCK_ON_LAST=0. It runs a directed vector table, the lock and reset
//   sequences, and randomized traffic checked against a lane-level model.
// ---------------------------------------------------------------------------
module tb_arb_mux_4x1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic [3:0]       tv[2];
   logic [3:0]       tl[2];
   logic [3:0][7:0]  td[2];
   logic             tordy[2];
   logic [3:0]       trdy[2];
   logic [7:0]       tod[2];
   logic [1:0]       tos[2];
   logic             tol[2];
   logic             tov[2];

   arb_mux_4x1 #(.ID(0), .WIDTH(8), .LOCK_ON_LAST(1)) u_lock (
      .clk(clk), .rst_n(rst_n), .in_data(td[0]), .in_valid(tv[0]),
      .in_last(tl[0]), .in_ready(trdy[0]), .out_data(tod[0]), .out_sel(tos[0]),
      .out_last(tol[0]), .out_valid(tov[0]), .out_ready(tordy[0]));

   arb_mux_4x1 #(.ID(1), .WIDTH(8), .LOCK_ON_LAST(0)) u_nolock (
      .clk(clk), .rst_n(rst_n), .in_data(td[1]), .in_valid(tv[1]),
      .in_last(tl[1]), .in_ready(trdy[1]), .out_data(tod[1]), .out_sel(tos[1]),
      .out_last(tol[1]), .out_valid(tov[1]), .out_ready(tordy[1]));

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- lane-level reference model ----------------
   // nxt: lane the next round-robin scan starts at; lk: locked lane or -1.
   typedef struct {
      int         nxt;
      int         lk;
      bit         ov;
      logic [7:0] od;
      int         os;
      bit         ol;
   } mdl_t;

   function automatic mdl_t m_init();
      mdl_t m;
      m.nxt = 0; m.lk = -1; m.ov = 0; m.od = 8'h00; m.os = 0; m.ol = 0;
      return m;
   endfunction

   function automatic int m_cand(mdl_t m, logic [3:0] v);
      if (m.lk >= 0) return v[m.lk] ? m.lk : -1;
      for (int k = 0; k < 4; k++)
         if (v[(m.nxt + k) % 4]) return (m.nxt + k) % 4;
      return -1;
   endfunction

   function automatic logic [3:0] m_ready(mdl_t m, logic [3:0] v, logic ordy);
      int c;
      c = m_cand(m, v);
      if (c >= 0 && (!m.ov || ordy)) return 4'(1 << c);
      return 4'b0000;
   endfunction

   function automatic mdl_t m_step(mdl_t m, logic [3:0] v, logic [3:0] l,
                                   logic [3:0][7:0] dat, logic ordy, bit lockp);
      int c;
      c = m_cand(m, v);
      if (c >= 0 && (!m.ov || ordy)) begin
         m.ov = 1; m.od = dat[c]; m.os = c; m.ol = l[c];
         if (m.lk < 0) begin
            m.nxt = (c + 1) % 4;
            if (lockp && !l[c]) m.lk = c;
         end else if (l[c]) begin
            m.lk = -1;
         end
      end else if (ordy) begin
         m.ov = 0;
      end
      return m;
   endfunction

   // ---------------- helpers ----------------
   task automatic clr();
      for (int d = 0; d < 2; d++) begin
         tv[d] = 4'b0; tl[d] = 4'b0; td[d] = '0; tordy[d] = 1'b0;
      end
   endtask

   task automatic do_reset();
      clr();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // ---------------- directed vector table (lock instance) ----------------
   typedef struct {
      logic [3:0]      v;
      logic [3:0]      l;
      logic [3:0][7:0] dat;
      logic            ordy;
      logic [3:0]      rdy;
      logic            ov;
      logic [1:0]      os;
      logic [7:0]      od;
      logic            ol;
   } vec_t;

   vec_t tbl[13];

   // ---------------- lock / interleave sequence ----------------
   // lane2 sends 11,22,33 (last on 33); lane0 raises one beat 44 a cycle later.
   task automatic run_lock(input int d, input logic [3:0][1:0] es, input logic [3:0][7:0] ed);
      logic [7:0] q2[$];
      logic [7:0] q0[$];
      int got;
      q2 = '{8'h11, 8'h22, 8'h33};
      q0 = '{8'h44};
      got = 0;
      do_reset();
      for (int c = 0; c < 20 && got < 4; c++) begin
         tv[d] = 4'b0; tl[d] = 4'b0; td[d] = '0; tordy[d] = 1'b1;
         if (q2.size() > 0) begin
            tv[d][2] = 1'b1; td[d][2] = q2[0]; tl[d][2] = (q2.size() == 1);
         end
         if (c >= 1 && q0.size() > 0) begin
            tv[d][0] = 1'b1; td[d][0] = q0[0]; tl[d][0] = 1'b1;
         end
         @(negedge clk);
         if (tov[d]) begin
            check($sformatf("lock%0d_sel%0d", d, got), 32'(tos[d]), 32'(es[got]));
            check($sformatf("lock%0d_dat%0d", d, got), 32'(tod[d]), 32'(ed[got]));
            got++;
         end
         if (tv[d][2] && trdy[d][2]) void'(q2.pop_front());
         if (tv[d][0] && trdy[d][0]) void'(q0.pop_front());
         @(posedge clk); #1;
      end
      check($sformatf("lock%0d_beats", d), 32'(got), 32'd4);
      clr();
   endtask

   // ---------------- randomized traffic vs model ----------------
   // Sources hold valid/data/last steady until accepted.
   task automatic run_rand(input int d, input int n, input bit lockp);
      mdl_t       m;
      logic [3:0] hold;
      logic [3:0] exp;
      do_reset();
      m    = m_init();
      hold = 4'b0;
      for (int c = 0; c < n; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (!hold[i]) begin
               tv[d][i] = 1'($urandom_range(0, 1));
               td[d][i] = 8'($urandom);
               tl[d][i] = ($urandom_range(0, 2) == 0);
            end
         end
         tordy[d] = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         exp = m_ready(m, tv[d], tordy[d]);
         check($sformatf("rnd%0d_rdy", d),  32'(trdy[d]), 32'(exp));
         check($sformatf("rnd%0d_ov", d),   32'(tov[d]),  32'(m.ov));
         check($sformatf("rnd%0d_od", d),   32'(tod[d]),  32'(m.od));
         check($sformatf("rnd%0d_os", d),   32'(tos[d]),  32'(m.os));
         check($sformatf("rnd%0d_ol", d),   32'(tol[d]),  32'(m.ol));
         hold = tv[d] & ~trdy[d];
         m = m_step(m, tv[d], tl[d], td[d], tordy[d], lockp);
         @(posedge clk); #1;
      end
      clr();
   endtask

   // ---------------- main ----------------
   initial begin
      logic [3:0][7:0] dq;
      dq = {8'h13, 8'h12, 8'h11, 8'h10};

      //           v        l        dat                              ordy  rdy      ov  os    od     ol
      tbl[0]  = '{4'b0010, 4'b0010, {8'h00, 8'h00, 8'hA5, 8'h00}, 1'b1, 4'b0010, 1'b0, 2'd0, 8'h00, 1'b0};
      tbl[1]  = '{4'b0000, 4'b0000, '0,                            1'b1, 4'b0000, 1'b1, 2'd1, 8'hA5, 1'b1};
      tbl[2]  = '{4'b1111, 4'b1111, dq,                            1'b1, 4'b0100, 1'b0, 2'd1, 8'hA5, 1'b1};
      tbl[3]  = '{4'b1111, 4'b1111, dq,                            1'b1, 4'b1000, 1'b1, 2'd2, 8'h12, 1'b1};
      tbl[4]  = '{4'b1111, 4'b1111, dq,                            1'b1, 4'b0001, 1'b1, 2'd3, 8'h13, 1'b1};
      tbl[5]  = '{4'b1111, 4'b1111, dq,                            1'b1, 4'b0010, 1'b1, 2'd0, 8'h10, 1'b1};
      tbl[6]  = '{4'b1111, 4'b1111, dq,                            1'b1, 4'b0100, 1'b1, 2'd1, 8'h11, 1'b1};
      tbl[7]  = '{4'b1111, 4'b1111, dq,                            1'b0, 4'b0000, 1'b1, 2'd2, 8'h12, 1'b1};
      tbl[8]  = '{4'b1111, 4'b1111, dq,                            1'b0, 4'b0000, 1'b1, 2'd2, 8'h12, 1'b1};
      tbl[9]  = '{4'b1111, 4'b1111, dq,                            1'b0, 4'b0000, 1'b1, 2'd2, 8'h12, 1'b1};
      tbl[10] = '{4'b1111, 4'b1111, dq,                            1'b1, 4'b1000, 1'b1, 2'd2, 8'h12, 1'b1};
      tbl[11] = '{4'b0000, 4'b0000, '0,                            1'b1, 4'b0000, 1'b1, 2'd3, 8'h13, 1'b1};
      tbl[12] = '{4'b0000, 4'b0000, '0,                            1'b0, 4'b0000, 1'b0, 2'd3, 8'h13, 1'b1};

      // Reset state, with all lanes valid to show ready stays low in reset.
      clr();
      rst_n = 1'b0;
      tv[0] = 4'b1111; tordy[0] = 1'b1;
      #3;
      check("rst_rdy", 32'(trdy[0]), 32'd0);
      check("rst_ov",  32'(tov[0]),  32'd0);
      check("rst_od",  32'(tod[0]),  32'd0);
      check("rst_os",  32'(tos[0]),  32'd0);
      check("rst_ol",  32'(tol[0]),  32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      clr();

      // Single lane, round robin, backpressure.
      for (int i = 0; i < 13; i++) begin
         tv[0] = tbl[i].v; tl[0] = tbl[i].l; td[0] = tbl[i].dat; tordy[0] = tbl[i].ordy;
         @(negedge clk);
         check($sformatf("tbl%0d_rdy", i), 32'(trdy[0]), 32'(tbl[i].rdy));
         check($sformatf("tbl%0d_ov", i),  32'(tov[0]),  32'(tbl[i].ov));
         check($sformatf("tbl%0d_os", i),  32'(tos[0]),  32'(tbl[i].os));
         check($sformatf("tbl%0d_od", i),  32'(tod[0]),  32'(tbl[i].od));
         check($sformatf("tbl%0d_ol", i),  32'(tol[0]),  32'(tbl[i].ol));
         @(posedge clk); #1;
      end
      clr();

      // Packet lock versus interleave (es/ed element 0 is the first beat).
      run_lock(0, {2'd0, 2'd2, 2'd2, 2'd2}, {8'h44, 8'h33, 8'h22, 8'h11});
      run_lock(1, {2'd2, 2'd2, 2'd0, 2'd2}, {8'h33, 8'h22, 8'h44, 8'h11});

      // Reset dropped mid-LOCK with a beat held.
      do_reset();
      tv[0] = 4'b0100; tl[0] = 4'b0000; td[0][2] = 8'h55; tordy[0] = 1'b1;
      @(posedge clk); #1;
      tv[0] = 4'b1111; tl[0] = 4'b0000;
      #1;
      check("mid_lock_rdy", 32'(trdy[0]), 32'b0100);
      check("mid_lock_ov",  32'(tov[0]),  32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_ov",  32'(tov[0]),  32'd0);
      check("async_rst_rdy", 32'(trdy[0]), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tv[0] = 4'b1111; tl[0] = 4'b1111; tordy[0] = 1'b1;
      #1;
      check("post_rst_rdy", 32'(trdy[0]), 32'b0001);
      @(posedge clk); #1;
      check("post_rst_os", 32'(tos[0]), 32'd0);
      check("post_rst_ov", 32'(tov[0]), 32'd1);
      clr();

      run_rand(0, 300, 1'b1);
      run_rand(1, 300, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
